// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single byte-wide RAM/IO port between the instruction
// fetcher and the load-store buffer. Word requests become 1..4 byte transfers;
// read bytes are reassembled little-endian. Round-robin arbitration on ties,
// speculative reads abort on rollback, IO stores stall while the UART is full.
//
// Handshake: a requester raises req with its operands stable and holds them
// until the matching done pulse (one cycle); it drops req in that done cycle.
// Requests are only sampled in IDLE, so back-to-back transfers always see one
// IDLE cycle between the done pulse and the next grant.
module mem_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rdy,
    input  logic              i_rollback,
    input  logic              i_io_buffer_full,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_done,
    output logic [31:0]       o_if_data,
    input  logic              i_lsb_req,
    input  logic              i_lsb_wr,
    input  logic [ADDR_W-1:0] i_lsb_addr,
    input  logic [2:0]        i_lsb_len,
    input  logic [31:0]       i_lsb_wdata,
    output logic              o_lsb_done,
    output logic [31:0]       o_lsb_rdata,
    input  logic [7:0]        i_mem_din,
    output logic [7:0]        o_mem_dout,
    output logic [ADDR_W-1:0] o_mem_a,
    output logic              o_mem_wr,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [2:0]        r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_acc;
    logic              r_last_lsb;   // 1: last grant went to the LSB (or reset)
    logic [ADDR_W-1:0] r_mem_a;
    logic [7:0]        r_mem_dout;
    logic              r_if_done;
    logic              r_lsb_done;
    logic [31:0]       r_if_data;
    logic [31:0]       r_lsb_rdata;

    logic              w_sample;
    logic              w_gnt_if;
    logic [2:0]        w_lsb_len;
    logic              w_io_hold;
    logic [2:0]        w_next_cnt;
    logic [ADDR_W-1:0] w_next_a;
    logic [31:0]       w_acc_next;
    logic [7:0]        w_wbyte;

    assign w_sample   = (r_state == IDLE) && !i_rollback && !r_if_done && !r_lsb_done;
    assign w_gnt_if   = i_if_req && (!i_lsb_req || r_last_lsb);
    assign w_lsb_len  = (i_lsb_len == 3'd1) ? 3'd1 : (i_lsb_len == 3'd2) ? 3'd2 : 3'd4;
    assign w_io_hold  = (r_addr[17:16] == IO_SEL) && i_io_buffer_full;
    assign w_next_cnt = r_cnt + 3'd1;
    assign w_next_a   = r_addr + ADDR_W'(w_next_cnt);

    // Accumulator with the byte arriving this cycle merged in; the byte on
    // i_mem_din belongs to the address presented one cycle earlier.
    always_comb begin
        w_acc_next = r_acc;
        case (r_cnt)
            3'd1:    w_acc_next[7:0]   = i_mem_din;
            3'd2:    w_acc_next[15:8]  = i_mem_din;
            3'd3:    w_acc_next[23:16] = i_mem_din;
            3'd4:    w_acc_next[31:24] = i_mem_din;
            default: w_acc_next        = r_acc;
        endcase
    end

    // Store byte for the next write beat.
    always_comb begin
        case (w_next_cnt[1:0])
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            2'd3:    w_wbyte = r_wdata[31:24];
            default: w_wbyte = r_wdata[7:0];
        endcase
    end

    // Arbitration and byte sequencing FSM; everything holds while i_rdy is low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_acc       <= '0;
            r_last_lsb  <= 1'b1;
            r_mem_a     <= '0;
            r_mem_dout  <= '0;
            r_if_done   <= 1'b0;
            r_lsb_done  <= 1'b0;
            r_if_data   <= '0;
            r_lsb_rdata <= '0;
        end else if (i_rdy) begin
            case (r_state)
                IDLE: begin
                    if (w_sample && (i_if_req || i_lsb_req)) begin
                        r_cnt <= '0;
                        r_acc <= '0;
                        if (w_gnt_if) begin
                            r_addr     <= i_if_addr;
                            r_mem_a    <= i_if_addr;
                            r_len      <= 3'd4;
                            r_last_lsb <= 1'b0;
                            r_state    <= RD;
                        end else begin
                            r_addr     <= i_lsb_addr;
                            r_mem_a    <= i_lsb_addr;
                            r_len      <= w_lsb_len;
                            r_wdata    <= i_lsb_wdata;
                            r_last_lsb <= 1'b1;
                            if (i_lsb_wr) begin
                                r_mem_dout <= i_lsb_wdata[7:0];
                                r_state    <= WR;
                            end else begin
                                r_state    <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (i_rollback) begin
                        r_state <= IDLE;
                        r_mem_a <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_cnt == r_len) begin
                            r_state <= DONE;
                            r_mem_a <= '0;
                            r_cnt   <= '0;
                            if (r_last_lsb) begin
                                r_lsb_rdata <= w_acc_next;
                                r_lsb_done  <= 1'b1;
                            end else begin
                                r_if_data <= w_acc_next;
                                r_if_done <= 1'b1;
                            end
                        end else begin
                            r_cnt   <= w_next_cnt;
                            r_mem_a <= (w_next_cnt < r_len) ? w_next_a : '0;
                        end
                    end
                end
                WR: begin
                    // Stores are committed: rollback is not looked at here.
                    if (!w_io_hold) begin
                        if (w_next_cnt == r_len) begin
                            r_state    <= DONE;
                            r_lsb_done <= 1'b1;
                            r_mem_a    <= '0;
                            r_mem_dout <= '0;
                            r_cnt      <= '0;
                        end else begin
                            r_cnt      <= w_next_cnt;
                            r_mem_a    <= w_next_a;
                            r_mem_dout <= w_wbyte;
                        end
                    end
                end
                default: begin
                    r_if_done  <= 1'b0;
                    r_lsb_done <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign o_mem_wr    = (r_state == WR) && i_rdy && !w_io_hold;
    assign o_mem_a     = r_mem_a;
    assign o_mem_dout  = r_mem_dout;
    assign o_if_done   = r_if_done;
    assign o_if_data   = r_if_data;
    assign o_lsb_done  = r_lsb_done;
    assign o_lsb_rdata = r_lsb_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model, word-level reference model and
// queue-based scoreboard with a monitor that checks every done pulse and
// every RAM write beat.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic              rollback = 1'b0;
  logic              io_full = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_done;
  logic [31:0]       if_data;
  logic              lsb_req = 1'b0;
  logic              lsb_wr = 1'b0;
  logic [ADDR_W-1:0] lsb_addr = '0;
  logic [2:0]        lsb_len = '0;
  logic [31:0]       lsb_wdata = '0;
  logic              lsb_done;
  logic [31:0]       lsb_rdata;
  logic [7:0]        mem_din = '0;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic [1:0]        dbg_state;

  mem_arbiter #(.ADDR_W(ADDR_W), .IO_SEL(2'b11)) dut (
    .i_clk(clk), .i_rst(rst), .i_rdy(rdy), .i_rollback(rollback),
    .i_io_buffer_full(io_full),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_done(if_done), .o_if_data(if_data),
    .i_lsb_req(lsb_req), .i_lsb_wr(lsb_wr), .i_lsb_addr(lsb_addr), .i_lsb_len(lsb_len),
    .i_lsb_wdata(lsb_wdata), .o_lsb_done(lsb_done), .o_lsb_rdata(lsb_rdata),
    .i_mem_din(mem_din), .o_mem_dout(mem_dout), .o_mem_a(mem_a), .o_mem_wr(mem_wr),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model and reference memory ----------------
  logic [7:0] ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      if (mem_wr) ram[mem_a] = mem_dout;
      if (rdy) mem_din <= ram_rd(mem_a);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        is_load;
    logic [31:0] data;
  } lsb_exp_t;

  logic [31:0] if_exp_q[$];
  lsb_exp_t    lsb_exp_q[$];
  logic [39:0] wr_exp_q[$];
  logic [31:0] last_rdata = '0;
  lsb_exp_t    lsb_e;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a result or write beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (!rdy) check("freeze_mem_wr", {63'd0, mem_wr}, 64'd0);
      if (if_done) begin
        if (if_exp_q.size() == 0) check("if_done_spurious", {63'd0, if_done}, 64'd0);
        else check("if_data", {32'd0, if_data}, {32'd0, if_exp_q.pop_front()});
      end
      if (lsb_done) begin
        if (lsb_exp_q.size() == 0) check("lsb_done_spurious", {63'd0, lsb_done}, 64'd0);
        else begin
          lsb_e = lsb_exp_q.pop_front();
          if (lsb_e.is_load) begin
            check("lsb_rdata", {32'd0, lsb_rdata}, {32'd0, lsb_e.data});
            last_rdata = lsb_e.data;
          end else begin
            check("lsb_rdata_after_store", {32'd0, lsb_rdata}, {32'd0, last_rdata});
          end
        end
      end
      if (mem_wr) begin
        if (wr_exp_q.size() == 0) check("mem_wr_spurious", {63'd0, mem_wr}, 64'd0);
        else check("mem_write", {24'd0, mem_a, mem_dout}, {24'd0, wr_exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the done pulse of the current transfer; t is the cycle in which
  // the request was raised, k counts cycles since then.
  task automatic wait_done(input bit is_if, input logic [31:0] a, input int n,
                           input bit is_read, input int exp_lat, input bit chk_lat,
                           input bit freeze);
    int k;
    bit got;
    k = 0;
    got = 1'b0;
    while (k < 200 && !got) begin
      tick();
      k++;
      if (freeze) begin
        if (k == 2) rdy = 1'b0;
        if (k == 7) rdy = 1'b1;
      end
      if (chk_lat && !freeze && is_read && k >= 1 && k <= n)
        check("rd_mem_a", {32'd0, mem_a}, {32'd0, a + 32'(k - 1)});
      got = is_if ? if_done : lsb_done;
    end
    check("done_seen", {63'd0, got}, 64'd1);
    if (got && chk_lat) check("latency", 64'(k), 64'(exp_lat));
  endtask

  task automatic if_read_exp(input logic [31:0] a, input logic [31:0] e, input bit chk_lat);
    tick();
    if_exp_q.push_back(e);
    if_addr = a;
    if_req = 1'b1;
    wait_done(1'b1, a, 4, 1'b1, 6, chk_lat, 1'b0);
    if_req = 1'b0;
  endtask

  task automatic if_read(input logic [31:0] a, input bit chk_lat);
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < 4; i++) e[8*i +: 8] = ref_rd(a + 32'(i));
    if_read_exp(a, e, chk_lat);
  endtask

  function automatic int len_of(input logic [2:0] len);
    return (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
  endfunction

  task automatic lsb_op(input bit wr, input logic [31:0] a, input logic [2:0] len,
                        input logic [31:0] wd, input bit chk_lat, input bit freeze);
    int n;
    int lat;
    lsb_exp_t e;
    logic [31:0] d;
    n = len_of(len);
    tick();
    d = '0;
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        wr_exp_q.push_back({a + 32'(i), wd[8*i +: 8]});
        ref_mem[a + 32'(i)] = wd[8*i +: 8];
      end
      lat = n + 1;
    end else begin
      for (int i = 0; i < n; i++) d[8*i +: 8] = ref_rd(a + 32'(i));
      lat = n + 2;
    end
    if (freeze) lat += 5;
    e.is_load = !wr;
    e.data = d;
    lsb_exp_q.push_back(e);
    lsb_wr = wr;
    lsb_addr = a;
    lsb_len = len;
    lsb_wdata = wd;
    lsb_req = 1'b1;
    wait_done(1'b0, a, n, !wr, lat, chk_lat, freeze);
    lsb_req = 1'b0;
  endtask

  // Both requesters raised together; records which one finishes first.
  task automatic tie(input logic [31:0] ia, input logic [31:0] la, input bit exp_if_first);
    logic [31:0] e;
    lsb_exp_t le;
    bit seen_if, seen_lsb, if_first;
    int k;
    tick();
    e = '0;
    for (int i = 0; i < 4; i++) e[8*i +: 8] = ref_rd(ia + 32'(i));
    if_exp_q.push_back(e);
    le.is_load = 1'b1;
    le.data = {24'd0, ref_rd(la)};
    lsb_exp_q.push_back(le);
    if_addr = ia;
    lsb_addr = la;
    lsb_wr = 1'b0;
    lsb_len = 3'd1;
    if_req = 1'b1;
    lsb_req = 1'b1;
    seen_if = 1'b0;
    seen_lsb = 1'b0;
    if_first = 1'b0;
    k = 0;
    while (k < 100 && !(seen_if && seen_lsb)) begin
      tick();
      k++;
      if (if_done) begin
        if_req = 1'b0;
        if (!seen_lsb) if_first = 1'b1;
        seen_if = 1'b1;
      end
      if (lsb_done) begin
        lsb_req = 1'b0;
        seen_lsb = 1'b1;
      end
    end
    if_req = 1'b0;
    lsb_req = 1'b0;
    check("tie_both_served", {62'd0, seen_if, seen_lsb}, 64'd3);
    check("tie_order_if_first", {63'd0, if_first}, {63'd0, exp_if_first});
  endtask

  task automatic io_throttle();
    lsb_exp_t e;
    int k;
    bit got;
    tick();
    wr_exp_q.push_back({32'h0003_0000, 8'h41});
    ref_mem[32'h0003_0000] = 8'h41;
    e.is_load = 1'b0;
    e.data = '0;
    lsb_exp_q.push_back(e);
    lsb_wr = 1'b1;
    lsb_addr = 32'h0003_0000;
    lsb_len = 3'd1;
    lsb_wdata = 32'h0000_0041;
    io_full = 1'b1;
    lsb_req = 1'b1;
    k = 0;
    got = 1'b0;
    while (k < 50 && !got) begin
      tick();
      k++;
      if (k <= 3) check("io_hold_mem_wr", {63'd0, mem_wr}, 64'd0);
      if (k == 4) io_full = 1'b0;
      got = lsb_done;
    end
    lsb_req = 1'b0;
    check("io_done_seen", {63'd0, got}, 64'd1);
    check("io_latency", 64'(k), 64'd5);
  endtask

  task automatic rollback_abort();
    tick();
    if_addr = 32'h0000_0040;
    if_req = 1'b1;
    tick();
    tick();
    tick();
    check("rb_third_byte_addr", {32'd0, mem_a}, 64'h42);
    rollback = 1'b1;
    if_req = 1'b0;
    tick();
    rollback = 1'b0;
    check("rb_mem_a_zero", {32'd0, mem_a}, 64'd0);
    check("rb_state_idle", {62'd0, dbg_state}, 64'd0);
    repeat (8) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_a"}, {32'd0, mem_a}, 64'd0);
    check({tag, "_mem_dout"}, {56'd0, mem_dout}, 64'd0);
    check({tag, "_mem_wr"}, {63'd0, mem_wr}, 64'd0);
    check({tag, "_dones"}, {62'd0, if_done, lsb_done}, 64'd0);
    check({tag, "_if_data"}, {32'd0, if_data}, 64'd0);
    check({tag, "_lsb_rdata"}, {32'd0, lsb_rdata}, 64'd0);
    check({tag, "_state"}, {62'd0, dbg_state}, 64'd0);
  endtask

  task automatic reset_mid_store();
    lsb_exp_t e;
    tick();
    // Only the first two beats complete before reset hits.
    for (int i = 0; i < 2; i++) begin
      wr_exp_q.push_back({32'h300 + 32'(i), 8'(32'hDEAD_BEEF >> (8 * i))});
      ref_mem[32'h300 + 32'(i)] = 8'(32'hDEAD_BEEF >> (8 * i));
    end
    lsb_wr = 1'b1;
    lsb_addr = 32'h300;
    lsb_len = 3'd4;
    lsb_wdata = 32'hDEAD_BEEF;
    lsb_req = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_mem_wr", {63'd0, mem_wr}, 64'd1);
    rst = 1'b1;
    lsb_req = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    last_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    e.is_load = 1'b1;
    e.data = '0;
    if (lsb_exp_q.size() != 0) e = lsb_exp_q[0];
    check("no_pending_after_rst", 64'(lsb_exp_q.size()), 64'd0);
  endtask

  bit rand_full_en = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (rand_full_en) io_full = 1'($urandom_range(0, 1));
  end

  task automatic run_random(input int count);
    logic [31:0] a;
    bit wr;
    logic [2:0] len;
    for (int n = 0; n < count; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, 255));
        1:       a = 32'h0003_0000 + 32'($urandom_range(0, 15));
        2:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: a = 32'h400 + 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 9) < 3) begin
        if_read(a, 1'b1);
      end else begin
        wr = 1'($urandom_range(0, 1));
        len = 3'($urandom_range(0, 7));
        lsb_op(wr, a, len, $urandom(), !(wr && a[17:16] == 2'b11), 1'b0);
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05;
    ref_mem[32'h102] = 8'h00; ref_mem[32'h103] = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Ties: IF wins from reset, and again after the LSB was served last.
    tie(32'h0, 32'h10, 1'b1);
    tie(32'h8, 32'h18, 1'b1);

    // Instruction fetch with fixed contents.
    if_read_exp(32'h100, 32'h0000_0513, 1'b1);
    // After an IF grant, a tie goes to the LSB.
    tie(32'h20, 32'h28, 1'b0);

    // Half-word store then reload.
    lsb_op(1'b1, 32'h200, 3'd2, 32'hABCD_1234, 1'b1, 1'b0);
    lsb_op(1'b0, 32'h200, 3'd2, 32'h0, 1'b1, 1'b0);

    rollback_abort();
    lsb_op(1'b0, 32'h20, 3'd4, 32'h0, 1'b1, 1'b0);

    io_throttle();

    // Freeze in the middle of a load and of a store.
    lsb_op(1'b0, 32'h200, 3'd4, 32'h0, 1'b1, 1'b1);
    lsb_op(1'b1, 32'h210, 3'd4, 32'h1122_3344, 1'b1, 1'b1);
    lsb_op(1'b0, 32'h210, 3'd4, 32'h0, 1'b1, 1'b0);

    rand_full_en = 1'b1;
    run_random(60);
    rand_full_en = 1'b0;
    tick();
    io_full = 1'b0;

    reset_mid_store();
    lsb_op(1'b0, 32'h300, 3'd4, 32'h0, 1'b1, 1'b0);

    repeat (4) tick();
    check("if_q_drained", 64'(if_exp_q.size()), 64'd0);
    check("lsb_q_drained", 64'(lsb_exp_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Byte-serial memory bus arbiter and sequencer that shares the single 8-bit RAM/IO port between the instruction fetcher and the load-store buffer. It accepts word-level requests, converts them into 1–4 sequential byte transfers, and reassembles read data little-endian. It applies round-robin arbitration, aborts speculative reads on rollback, and throttles IO writes while the UART buffer is full. It sits between the front end/LSB and the top-level memory pins.

## Interface
- ADDR_W, 32, address width
- IO_SEL, 2'b11, value of addr[17:16] that selects the IO region
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; low freezes all state
- rollback  in  1  pipeline flush
- io_buffer_full  in  1  UART buffer full
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address (4-byte read)
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched instruction
- lsb_req  in  1  LSB request, held until lsb_done
- lsb_wr  in  1  1 = store
- lsb_addr  in  ADDR_W  byte address
- lsb_len  in  3  bytes: 1, 2, 4 (other values treated as 4)
- lsb_wdata  in  32  store data, byte k = bits 8k+7:8k
- lsb_done  out  1  one-cycle pulse
- lsb_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM address
- mem_wr  out  1  1 = write

## Operation
- States: IDLE, RD, WR, DONE. A byte counter cnt (0..4) and an accumulator hold transfer progress.
- IDLE: the block samples requests only when rdy=1, rollback=0 and no done pulse is high.
  - One requester pending: that requester is granted.
  - Both pending: the requester not granted last is granted. last_gnt resets to LSB, so IF wins the first tie.
- Grant latches addr, len (IF: 4), wr and wdata, then enters RD or WR.
- RD: presents addr+cnt on mem_a for cnt = 0..N-1, one byte per cycle.
  - mem_din in the cycle after address k is captured into byte k.
  - After byte N-1 is captured: go to DONE, load if_data/lsb_rdata, pulse the matching done.
- WR: for each byte, presents addr+cnt, wdata byte cnt and mem_wr=1.
  - IO hold: if addr[17:16]==IO_SEL and io_buffer_full=1 in that cycle, mem_wr=0 and cnt holds (retry next cycle).
  - After the last byte: go to DONE and pulse lsb_done.
- DONE: one cycle, then back to IDLE. The requester drops req in the DONE cycle.
- Rollback in RD:
  - Abort at the next edge: go to IDLE, mem_a←0, no done pulse, partial data discarded.
  - Applies to both IF and LSB reads; LSB reads are speculative.
- Rollback in WR: ignored. Stores are committed and always complete.
- Rollback in DONE: the done pulse still occurs; the requester ignores it.
- Address arithmetic: addr+cnt is modulo 2^ADDR_W, with no alignment check.
- Idle bus: mem_a=0, mem_wr=0, mem_dout=0.
- rdy=0: all registers hold and mem_wr is gated to 0 combinationally. mem_din is sampled only on rdy=1 edges; the system holds RAM output stable while rdy=0.

## Timing
- Reset values: mem_a=0, mem_dout=0, mem_wr=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0, state=IDLE, cnt=0, last_gnt=LSB.
- Outputs are registered except for the mem_wr rdy-gate.
- Read of N bytes, request sampled in cycle t:
  - mem_a=addr+k in cycle t+1+k.
  - Byte k captured at the end of cycle t+2+k.
  - done/data valid in cycle t+N+2.
  - The next request can be sampled in cycle t+N+3.
- Write of N bytes, no IO hold:
  - mem_wr=1 in cycles t+1..t+N.
  - lsb_done in cycle t+N+1.
  - Each IO hold cycle adds one cycle.
- Back-to-back transfers always have one IDLE sampling cycle between them.
- Reset asserted mid-transfer: outputs return to reset values immediately, with no done pulse and mem_wr deasserted asynchronously.

## Test plan
- **IF fetch:** if_req, if_addr=0x100, RAM 0x100..0x103 = 13 05 00 00 -> mem_a 0x100..0x103 in t+1..t+4; if_done with if_data=0x00000513 in t+6, single pulse.
- **LSB half store:** lsb_wr=1, len=2, addr=0x200, wdata=0xABCD1234 -> writes 0x34@0x200, 0x12@0x201; mem_wr high exactly 2 cycles; lsb_done in t+3.
- **Tie arbitration:**
  - Both requests asserted from reset (IF addr=0x0, LSB load len=1 addr=0x10) -> IF served first, then LSB.
  - Both re-asserted -> IF is granted next (last_gnt=LSB).
  - No request is lost.
- **Rollback abort:** rollback pulse during the 3rd byte of an IF read -> no if_done, mem_a=0 next cycle, state IDLE. A new LSB load of 4 bytes from 0x20 then returns correct data.
- **IO throttle:** store len=1, addr=0x30000, data 0x41, io_buffer_full high for 3 cycles -> mem_wr=0 for those cycles; one write of 0x41 on the first cycle after full drops; lsb_done one cycle later.
- **Reset and freeze:**
  - rst asserted mid-way through a 4-byte store -> mem_wr=0 immediately, all outputs at reset values, no lsb_done after release.
  - rdy low for 5 cycles mid-read -> mem_wr=0, the transfer resumes, and the result is unchanged.
